// File: rtl/ads8528_emulator.sv
// ads8528_emulator: deterministic stand-in for the ADS8528 on the ADC driver's
// parallel bus. Answers conversion starts, configuration writes and data reads.
// Optional feature: define ADS_EMU_LFSR_EN to source sample words from a 16-bit
// Fibonacci LFSR (seed 0xACE1) instead of the {channel, conversion count} pattern.
module ads8528_emulator #(
    parameter int unsigned CONV_CYCLES = 20,
    parameter int unsigned CNT_W       = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             convst_A,
    input  logic             convst_B,
    input  logic             convst_C,
    input  logic             convst_D,
    input  logic             CS,
    input  logic             read,
    input  logic             write,
    output logic             Busy,
    inout  wire  [15:0]      DB,
    output logic [31:0]      cfg,
    output logic             cfg_valid,
    output logic [CNT_W-1:0] conv_count
);

    localparam int unsigned DW    = 16;
    localparam int unsigned NCH   = 8;
    localparam int unsigned TW    = $clog2(CONV_CYCLES);
    localparam int unsigned PAT_W = 13;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    tmr, tmr_nxt;
    logic [3:0]       mask, mask_nxt;
    logic [3:0]       convst_q;
    logic             read_q, write_q;
    logic [DW-1:0]    sample [NCH];
    logic [DW-1:0]    sample_nxt [NCH];
    logic [2:0]       ptr;
    logic [DW-1:0]    dout;
    logic [DW-1:0]    wr_hold;
    logic             second_word;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [3:0]       convst_c, convst_rise_c;
    logic             rd_fall_c, wr_rise_c, rd_en_c;

    assign convst_c      = {convst_D, convst_C, convst_B, convst_A};
    assign convst_rise_c = convst_c & ~convst_q;
    assign rd_fall_c     = ~CS & write & ~read & read_q;
    assign wr_rise_c     = ~CS & write & ~write_q;
    assign rd_en_c       = ~CS & ~read & write;
    assign cnt_inc_c     = conv_count + CNT_W'(1);

    // Drive the bus only for a pure read cycle
    assign DB = rd_en_c ? dout : 'z;

`ifdef ADS_EMU_LFSR_EN
    logic [DW-1:0] lfsr, lfsr_nxt;

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Next sample words: one LFSR step per masked channel, in ptr order
    always_comb begin : p_sample
        logic [2:0]    k3;
        logic [DW-1:0] lv;
        k3         = '0;
        lv         = lfsr;
        sample_nxt = sample;
        for (int k = 0; k < NCH; k++) begin
            k3 = 3'(k);
            if (mask[k3[2:1]]) begin
                lv             = lfsr_step(lv);
                sample_nxt[k3] = lv;
            end
        end
        lfsr_nxt = lv;
    end
`else
    // Next sample words: {channel, post-increment conversion count}
    always_comb begin : p_sample
        logic [2:0] k3;
        k3         = '0;
        sample_nxt = sample;
        for (int k = 0; k < NCH; k++) begin
            k3 = 3'(k);
            if (mask[k3[2:1]]) begin
                sample_nxt[k3] = {k3, PAT_W'(cnt_inc_c)};
            end
        end
    end
`endif

    // Conversion FSM next-state logic
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        mask_nxt  = mask;
        case (state)
            IDLE: begin
                if (|convst_rise_c) begin
                    state_nxt = CONV;
                    tmr_nxt   = TW'(CONV_CYCLES - 1);
                    mask_nxt  = convst_rise_c;
                end
            end
            CONV: begin
                if (tmr == '0) begin
                    state_nxt = UPDATE;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register and Busy output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            mask  <= '0;
            Busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            mask  <= mask_nxt;
            Busy  <= (state == CONV);
        end
    end

    // Strobe history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            convst_q <= '0;
            read_q   <= 1'b1;
            write_q  <= 1'b1;
        end else begin
            convst_q <= convst_c;
            read_q   <= read;
            write_q  <= write;
        end
    end

    // Sample store, read pointer and read data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) sample[i] <= '0;
            conv_count <= '0;
            ptr        <= '0;
            dout       <= '0;
        end else begin
            if (rd_fall_c) begin
                dout <= sample[ptr];
                ptr  <= ptr + 3'd1;
            end
            if (state == UPDATE) begin
                sample     <= sample_nxt;
                conv_count <= cnt_inc_c;
                ptr        <= '0;
            end
        end
    end

`ifdef ADS_EMU_LFSR_EN
    // LFSR advances only when sample words are loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (state == UPDATE) begin
            lfsr <= lfsr_nxt;
        end
    end
`endif

    // Configuration write capture: word pair into cfg, pulse on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_hold     <= '0;
            cfg         <= '0;
            cfg_valid   <= 1'b0;
            second_word <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            if (~CS & ~write) begin
                wr_hold <= DB;
            end
            if (wr_rise_c) begin
                second_word <= ~second_word;
                if (second_word) begin
                    cfg[15:0] <= wr_hold;
                    cfg_valid <= 1'b1;
                end else begin
                    cfg[31:16] <= wr_hold;
                end
            end
        end
    end

endmodule

// File: tb/tb_ads8528_emulator.sv
// Directed bench for ads8528_emulator: conversions, readback order, config
// writes, retrigger immunity, pointer wrap, CS gating and mid-conversion reset.
module tb_ads8528_emulator;

    localparam int unsigned CONV_CYCLES = 20;
    localparam int unsigned CNT_W       = 13;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             convst_A = 1'b0, convst_B = 1'b0, convst_C = 1'b0, convst_D = 1'b0;
    logic             CS = 1'b1, read = 1'b1, write = 1'b1;
    logic             Busy;
    logic [31:0]      cfg;
    logic             cfg_valid;
    logic [CNT_W-1:0] conv_count;
    logic             db_oe = 1'b0;
    logic [15:0]      db_drv = '0;
    wire  [15:0]      db;

    int n_checks = 0;
    int n_errors = 0;

    // Expected state: sample words, read pointer, conversion count
    logic [15:0] smp_m [8];
    logic [2:0]  ptr_m;
    int          cnt_m;
    logic [15:0] lfsr_m;

    assign db = db_oe ? db_drv : 'z;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (db[i]);
    end

    always #5 clk = ~clk;

    ads8528_emulator #(.CONV_CYCLES(CONV_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .convst_A(convst_A), .convst_B(convst_B), .convst_C(convst_C), .convst_D(convst_D),
        .CS(CS), .read(read), .write(write),
        .Busy(Busy), .DB(db), .cfg(cfg), .cfg_valid(cfg_valid), .conv_count(conv_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) smp_m[3'(k)] = '0;
        ptr_m  = '0;
        cnt_m  = 0;
        lfsr_m = 16'hACE1;
    endtask

    task automatic model_conv(input logic [3:0] m);
        cnt_m = cnt_m + 1;
        for (int k = 0; k < 8; k++) begin
            if (m[2'(k / 2)]) begin
`ifdef ADS_EMU_LFSR_EN
                lfsr_m         = lfsr_next(lfsr_m);
                smp_m[3'(k)]   = lfsr_m;
`else
                smp_m[3'(k)]   = {3'(k), 13'(cnt_m)};
`endif
            end
        end
        ptr_m = '0;
    endtask

    // Start a conversion, optionally re-pulse convst_A after 'retrig' Busy cycles
    task automatic do_conv(input logic [3:0] m, input int retrig, input string tag);
        int n;
        n = 0;
        {convst_D, convst_C, convst_B, convst_A} = m;
        tick(1);
        {convst_D, convst_C, convst_B, convst_A} = 4'b0000;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            convst_A = 1'b0;
            if (Busy) begin
                n++;
                if (n == retrig) convst_A = 1'b1;
            end else if (n > 0) begin
                break;
            end
        end
        convst_A = 1'b0;
        model_conv(m);
        check({tag, "_busy_cycles"}, 32'(n), 32'(CONV_CYCLES));
        check({tag, "_conv_count"}, 32'(conv_count), 32'(cnt_m));
    endtask

    task automatic read_word(input logic cs_v, output logic [15:0] v);
        CS   = cs_v;
        read = 1'b0;
        tick(1);
        v    = db;
        read = 1'b1;
        tick(1);
        CS   = 1'b0;
    endtask

    task automatic read_chk(input string tag);
        logic [15:0] v;
        read_word(1'b0, v);
        check(tag, 32'(v), 32'(smp_m[ptr_m]));
        ptr_m = ptr_m + 3'd1;
    endtask

    // One configuration word; with_read also holds read low and leaves DB undriven
    task automatic write_word(input logic [15:0] v, input logic with_read);
        CS     = 1'b0;
        db_drv = v;
        db_oe  = ~with_read;
        write  = 1'b0;
        read   = ~with_read;
        tick(2);
        if (with_read) begin
            check("rw_db_not_driven", 32'(db), 32'hFFFF);
            read = 1'b1;
            tick(1);
        end
        write = 1'b1;
        db_oe = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [15:0] v;
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_cfg", cfg, 32'h0);
        check("rst_cfg_valid", 32'(cfg_valid), 32'h0);
        check("rst_conv_count", 32'(conv_count), 32'h0);
        check("rst_db_hiz", 32'(db), 32'hFFFF);
        CS = 1'b0;

        // All four pairs: words {k, 1}
        do_conv(4'b1111, 0, "conv1");
        for (int k = 0; k < 8; k++) read_chk($sformatf("conv1_rd%0d", k));

        // Only pair B refreshed
        do_conv(4'b0010, 0, "conv2");
        for (int k = 0; k < 8; k++) read_chk($sformatf("conv2_rd%0d", k));

        // Configuration pair 0x1500, 0x0000
        write_word(16'h1500, 1'b0);
        check("wr1_cfg", cfg, 32'h1500_0000);
        check("wr1_no_valid", 32'(cfg_valid), 32'h0);
        write_word(16'h0000, 1'b0);
        check("wr2_cfg", cfg, 32'h1500_0000);
        check("wr2_valid", 32'(cfg_valid), 32'h1);
        tick(1);
        check("wr2_valid_single", 32'(cfg_valid), 32'h0);

        // Read and write low together: bus stays undriven, read ignored
        write_word(16'h0000, 1'b1);
        check("rw1_cfg", cfg, 32'hFFFF_0000);
        write_word(16'h1234, 1'b0);
        check("rw2_cfg", cfg, 32'hFFFF_1234);
        check("rw2_valid", 32'(cfg_valid), 32'h1);
        read_chk("rw_ptr_held");

        // Retrigger 5 cycles into Busy is ignored
        do_conv(4'b1111, 5, "retrig");

        // Nine reads: ninth wraps back to A0
        for (int k = 0; k < 9; k++) read_chk($sformatf("wrap_rd%0d", k));
        read_word(1'b1, v);
        check("cs_high_db_hiz", 32'(v), 32'hFFFF);
        read_chk("cs_high_ptr_held");

        // Reset ten cycles into a conversion
        {convst_D, convst_C, convst_B, convst_A} = 4'b1111;
        tick(1);
        {convst_D, convst_C, convst_B, convst_A} = 4'b0000;
        tick(10);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(Busy), 32'h0);
        check("midrst_conv_count", 32'(conv_count), 32'h0);
        check("midrst_cfg", cfg, 32'h0);
        model_reset();
        tick(2);
        rst = 1'b0;
        tick(1);
        read_chk("midrst_rd_a0");
        read_chk("midrst_rd_a1");
        do_conv(4'b0001, 0, "postrst");
        read_chk("postrst_rd_a0");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
